// File: rtl/mem_access_unit.sv
// RV32 load/store initiator for the data memory: one request per handshake, sub-word loads
// extracted and extended, sub-word stores done as read-modify-write on the aligned word.
module mem_access_unit #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic              mem_write_en_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, word_q, rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [AWIDTH-1:0] offset;
    logic [DWIDTH-1:0] byte_shift, half_shift, load_data, merged;

    assign accept = req_valid_i && (state_q == IDLE);

    // Subtraction wraps for addresses below BASE_ADDR, so one compare covers both ends.
    assign offset = req_addr_i - BASE_ADDR;

    always_comb begin
        req_err = (offset >= MEM_BYTES);
        case (req_funct3_i)
            3'b000:         ;
            3'b001:         if (req_addr_i[0]) req_err = 1'b1;
            3'b010:         if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
            3'b100, 3'b101: begin
                if (req_we_i) req_err = 1'b1;
                if (req_funct3_i == 3'b101 && req_addr_i[0]) req_err = 1'b1;
            end
            default:        req_err = 1'b1;
        endcase
    end

    assign byte_shift = mem_data_i >> {addr_q[1:0], 3'b000};
    assign half_shift = mem_data_i >> {addr_q[1], 4'b0000};

    always_comb begin
        case (f3_q)
            3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_data = {24'd0, byte_shift[7:0]};
            3'b101:  load_data = {16'd0, half_shift[15:0]};
            default: load_data = mem_data_i;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (f3_q)
            3'b000:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    we_q    <= req_we_i;
                    f3_q    <= req_funct3_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    err_q   <= req_err;
                    rdata_q <= '0;
                    word_q  <= '0;
                end
                RD: begin
                    word_q <= mem_data_i;
                    if (!we_q) rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                if (req_err)                              state_d = RESP;
                else if (req_we_i && req_funct3_i == 3'b010) state_d = WR;
                else                                      state_d = RD;
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_err_o      = err_q;
    assign mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
    assign mem_data_o     = (state_q == WR) ? merged : '0;
    assign mem_read_en_o  = (state_q == RD) && !rst;
    assign mem_write_en_o = (state_q == WR) && !rst;

endmodule
